// File: rtl/reg_arbiter_pkg.sv
// Shared types and constants for the round-robin register arbiter.
package reg_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int WCNT_W = 8;

endpackage

// File: rtl/reg_arbiter_rr_pick.sv
// Combinational round-robin winner selection: first set request at or after the pointer.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [IW-1:0]   o_winner,
    output logic            o_valid
);

    // Walk offsets from the far end down so the smallest offset from the pointer wins.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % NREQ]) begin
                o_valid  = 1'b1;
                o_winner = IW'((int'(i_ptr) + k) % NREQ);
            end else begin
                o_valid  = o_valid;
            end
        end
    end

endmodule

// File: rtl/reg_arbiter.sv
// Shared-register write arbiter: IDLE picks a round-robin winner, GRANT commits its data.
// Optional macro ARB_LOCK_EN lets a locked winner write back-to-back without re-arbitrating.
module reg_arbiter
    import reg_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          REQ,
    input  logic [NREQ*WIDTH-1:0]    DATA,
    input  logic [NREQ-1:0]          LOCK,
    output logic [NREQ-1:0]          GNT,
    output logic [WIDTH-1:0]         R,
    output logic [$clog2(NREQ)-1:0]  OWNER,
    output logic                     BUSY,
    output logic [WCNT_W-1:0]        WCNT
);

    localparam int IW = $clog2(NREQ);

    state_t             r_state;
    logic [IW-1:0]      r_winner;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_owner;
    logic [WIDTH-1:0]   r_reg;
    logic [WCNT_W-1:0]  r_wcnt;

    logic [IW-1:0]      w_pick_idx;
    logic               w_pick_valid;
    logic               w_commit;
    logic               w_hold;
    logic [IW-1:0]      w_next_ptr;
    logic [NREQ-1:0]    w_gnt;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req    (REQ),
        .i_ptr    (r_ptr),
        .o_winner (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    assign w_commit   = (r_state == GRANT) && REQ[r_winner];
    assign w_next_ptr = (r_winner == IW'(NREQ - 1)) ? '0 : r_winner + IW'(1);

`ifdef ARB_LOCK_EN
    assign w_hold = LOCK[r_winner];
`else
    // Lock is accepted on the port but never influences this build.
    assign w_hold = LOCK[r_winner] & 1'b0;
`endif

    // Grant follows the winner's live request so a withdrawal shows as no grant.
    always_comb begin
        w_gnt = '0;
        if (r_state == GRANT) begin
            w_gnt[r_winner] = REQ[r_winner];
        end else begin
            w_gnt = '0;
        end
    end

    // Arbitration state machine and shared register; reset overrides a same-edge commit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_winner <= '0;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_reg    <= '0;
            r_wcnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_winner <= w_pick_idx;
                        r_state  <= GRANT;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                GRANT: begin
                    if (w_commit) begin
                        r_reg   <= DATA[int'(r_winner)*WIDTH +: WIDTH];
                        r_owner <= r_winner;
                        r_wcnt  <= r_wcnt + WCNT_W'(1);
                        if (w_hold) begin
                            r_state <= GRANT;
                        end else begin
                            r_ptr   <= w_next_ptr;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign GNT   = w_gnt;
    assign R     = r_reg;
    assign OWNER = r_owner;
    assign BUSY  = (r_state != IDLE);
    assign WCNT  = r_wcnt;

endmodule

// File: tb/tb_reg_arbiter.sv
// Table-driven bench for reg_arbiter with a scoreboard of expected register commits.
module tb_reg_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  lock;
    logic [3:0]  gnt;
    logic [7:0]  r;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  wcnt;

    int n_cmp;
    int n_err;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [7:0]  r;
        logic [1:0]  own;
        logic        busy;
        logic [7:0]  wcnt;
    } vec_t;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] val;
    } sb_t;

    vec_t vecs[24];
    sb_t  sbq[$];

    reg_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .CLK   (clk),
        .RST   (rst),
        .REQ   (req),
        .DATA  (data),
        .LOCK  (lock),
        .GNT   (gnt),
        .R     (r),
        .OWNER (owner),
        .BUSY  (busy),
        .WCNT  (wcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] d0;
        logic [31:0] d15;
        logic [31:0] d7;
        logic        pushed;
        sb_t         e;
        sb_t         got;

        n_cmp = 0;
        n_err = 0;
        d0  = 32'h04030201;
        d15 = 32'h000F0000;
        d7  = 32'h00000007;

        //            rst   req      data gnt      r      own   busy  wcnt
        vecs[0]  = '{1'b1, 4'b1111, d0,  4'b0000, 8'd0,  2'd0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 4'b1111, d0,  4'b0000, 8'd0,  2'd0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 4'b0100, d15, 4'b0000, 8'd0,  2'd0, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 4'b0100, d15, 4'b0100, 8'd0,  2'd0, 1'b1, 8'd0};
        vecs[4]  = '{1'b0, 4'b0000, d15, 4'b0000, 8'd15, 2'd2, 1'b0, 8'd1};
        vecs[5]  = '{1'b1, 4'b0000, d0,  4'b0000, 8'd15, 2'd2, 1'b0, 8'd1};
        vecs[6]  = '{1'b0, 4'b1111, d0,  4'b0000, 8'd0,  2'd0, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 4'b1111, d0,  4'b0001, 8'd0,  2'd0, 1'b1, 8'd0};
        vecs[8]  = '{1'b0, 4'b1111, d0,  4'b0000, 8'd1,  2'd0, 1'b0, 8'd1};
        vecs[9]  = '{1'b0, 4'b1111, d0,  4'b0010, 8'd1,  2'd0, 1'b1, 8'd1};
        vecs[10] = '{1'b0, 4'b1111, d0,  4'b0000, 8'd2,  2'd1, 1'b0, 8'd2};
        vecs[11] = '{1'b0, 4'b1111, d0,  4'b0100, 8'd2,  2'd1, 1'b1, 8'd2};
        vecs[12] = '{1'b0, 4'b1111, d0,  4'b0000, 8'd3,  2'd2, 1'b0, 8'd3};
        vecs[13] = '{1'b0, 4'b1111, d0,  4'b1000, 8'd3,  2'd2, 1'b1, 8'd3};
        vecs[14] = '{1'b0, 4'b1111, d0,  4'b0000, 8'd4,  2'd3, 1'b0, 8'd4};
        vecs[15] = '{1'b0, 4'b1111, d0,  4'b0001, 8'd4,  2'd3, 1'b1, 8'd4};
        vecs[16] = '{1'b0, 4'b0010, d0,  4'b0000, 8'd1,  2'd0, 1'b0, 8'd5};
        vecs[17] = '{1'b0, 4'b0000, d0,  4'b0000, 8'd1,  2'd0, 1'b1, 8'd5};
        vecs[18] = '{1'b0, 4'b1010, d0,  4'b0000, 8'd1,  2'd0, 1'b0, 8'd5};
        vecs[19] = '{1'b0, 4'b1010, d0,  4'b0010, 8'd1,  2'd0, 1'b1, 8'd5};
        vecs[20] = '{1'b0, 4'b0000, d0,  4'b0000, 8'd2,  2'd1, 1'b0, 8'd6};
        vecs[21] = '{1'b0, 4'b0001, d7,  4'b0000, 8'd2,  2'd1, 1'b0, 8'd6};
        vecs[22] = '{1'b1, 4'b0001, d7,  4'b0001, 8'd2,  2'd1, 1'b1, 8'd6};
        vecs[23] = '{1'b0, 4'b0000, d0,  4'b0000, 8'd0,  2'd0, 1'b0, 8'd0};

        rst  = 1'b1;
        req  = 4'b1111;
        data = d0;
        lock = 4'b0000;
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            rst  = vecs[i].rst;
            req  = vecs[i].req;
            data = vecs[i].data;
            @(negedge clk);
            check($sformatf("row%0d_gnt", i),   {28'd0, gnt},   {28'd0, vecs[i].gnt});
            check($sformatf("row%0d_r", i),     {24'd0, r},     {24'd0, vecs[i].r});
            check($sformatf("row%0d_owner", i), {30'd0, owner}, {30'd0, vecs[i].own});
            check($sformatf("row%0d_busy", i),  {31'd0, busy},  {31'd0, vecs[i].busy});
            check($sformatf("row%0d_wcnt", i),  {24'd0, wcnt},  {24'd0, vecs[i].wcnt});
            pushed = 1'b0;
            if (!vecs[i].rst && vecs[i].gnt != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (vecs[i].gnt[k]) begin
                        e.idx = 2'(k);
                        e.val = vecs[i].data[k*8 +: 8];
                    end
                end
                sbq.push_back(e);
                pushed = 1'b1;
            end
            @(posedge clk);
            #1;
            if (pushed) begin
                got = sbq.pop_front();
                check($sformatf("sb%0d_r", i),     {24'd0, r},     {24'd0, got.val});
                check($sformatf("sb%0d_owner", i), {30'd0, owner}, {30'd0, got.idx});
            end
        end

        check("sb_empty", sbq.size(), 32'd0);

        // Counter wrap with lock asserted, which this build must ignore.
        req  = 4'b0001;
        lock = 4'b1111;
        data = 32'h000000AA;
        repeat (510) @(posedge clk);
        #1;
        check("wrap_wcnt255", {24'd0, wcnt}, 32'd255);
        check("wrap_busy_idle", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        req = 4'b0000;
        check("wrap_wcnt0", {24'd0, wcnt}, 32'd0);
        check("wrap_r", {24'd0, r}, 32'h000000AA);
        check("wrap_owner", {30'd0, owner}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
